// File: rtl/exec_core_if.sv
// Issue and writeback port of the execute core. The issuer holds in_valid and all issue
// fields stable until a rising edge with in_valid && in_ready; wb_* and illegal are core outputs.
interface exec_core_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IMM_W = 12
);
  localparam int RA = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [RA-1:0]    dst;
  logic [RA-1:0]    src1;
  logic [RA-1:0]    src2;
  logic             has_imm;
  logic [IMM_W-1:0] imm;
  logic             wb_valid;
  logic [RA-1:0]    wb_dst;
  logic [XLEN-1:0]  wb_data;
  logic             illegal;

  modport master (
    output in_valid, op, dst, src1, src2, has_imm, imm,
    input  in_ready, wb_valid, wb_dst, wb_data, illegal
  );

  modport slave (
    input  in_valid, op, dst, src1, src2, has_imm, imm,
    output in_ready, wb_valid, wb_dst, wb_data, illegal
  );
endinterface

// File: rtl/exec_core.sv
// Execute core: register file, ALU with writeback forwarding, and a shift-add MUL
// that holds issue off for XLEN cycles.
module exec_core #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int IMM_W  = 12,
  parameter int MUL_EN = 1,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  exec_core_if.slave      bus,
  input  logic [RA-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [0:0]      dbg_state
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_wb_valid;
  logic [RA-1:0]   r_wb_dst;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [SW-1:0]   r_cnt;
  logic [RA-1:0]   r_mdst;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_res;
  logic [XLEN-1:0] w_mul_sum;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_legal;

  // Operand read: r0 is hard zero, otherwise the retiring result beats the not-yet-written register.
  always_comb begin
    w_a = '0;
    if (bus.src1 != '0)
      w_a = (r_wb_valid && r_wb_dst == bus.src1) ? r_wb_data : r_regs[bus.src1];
    w_b = '0;
    if (bus.has_imm)
      w_b = {{(XLEN-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    else if (bus.src2 != '0)
      w_b = (r_wb_valid && r_wb_dst == bus.src2) ? r_wb_data : r_regs[bus.src2];
  end

  always_comb begin
    w_res = '0;
    case (bus.op)
      4'd0:    w_res = w_a + w_b;
      4'd1:    w_res = w_a - w_b;
      4'd2:    w_res = w_a & w_b;
      4'd3:    w_res = w_a | w_b;
      4'd4:    w_res = w_a ^ w_b;
      4'd5:    w_res = w_a << w_b[SW-1:0];
      4'd6:    w_res = w_a >> w_b[SW-1:0];
      4'd7:    w_res = $signed(w_a) >>> w_b[SW-1:0];
      4'd8:    w_res = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      4'd9:    w_res = {{(XLEN-1){1'b0}}, w_a < w_b};
      default: w_res = '0;
    endcase
  end

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_is_mul  = (bus.op == 4'd10) && (MUL_EN != 0);
  assign w_legal   = (bus.op <= 4'd9) || w_is_mul;
  assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_wb_valid <= 1'b0;
      r_wb_dst   <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mdst     <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_wb_valid && r_wb_dst != '0) r_regs[r_wb_dst] <= r_wb_data;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state    <= S_MUL;
              r_in_ready <= 1'b0;
              r_mcand    <= w_a;
              r_mplier   <= w_b;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_mdst     <= bus.dst;
            end else if (w_legal) begin
              r_wb_valid <= 1'b1;
              r_wb_dst   <= bus.dst;
              r_wb_data  <= w_res;
            end else begin
              r_illegal  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per edge; the final iteration retires straight into wb.
          r_acc    <= w_mul_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == SW'(XLEN-1)) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_dst   <= r_mdst;
            r_wb_data  <= w_mul_sum;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_dst   = r_wb_dst;
  assign bus.wb_data  = r_wb_data;
  assign bus.illegal  = r_illegal;
  assign dbg_data     = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_exec_core.sv
// Directed bench for exec_core: issue driver pushes expected writebacks, a negedge
// monitor pops and compares them, plus direct checks of stalls, debug reads and reset.
module tb_exec_core;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IMM_W = 12;
  localparam int RA    = $clog2(NREGS);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [RA-1:0]   dbg_addr = '0;
  logic [XLEN-1:0] dbg_data;
  logic [0:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [RA+XLEN-1:0] exp_q[$];

  exec_core_if #(.XLEN(XLEN), .NREGS(NREGS), .IMM_W(IMM_W)) bus ();

  exec_core #(.XLEN(XLEN), .NREGS(NREGS), .IMM_W(IMM_W), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got dst=%0d data=0x%08h expected no writeback", bus.wb_dst, bus.wb_data);
      end else begin
        logic [RA+XLEN-1:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if ({bus.wb_dst, bus.wb_data} !== e) begin
          n_err++;
          $display("FAIL wb: got dst=%0d data=0x%08h expected dst=%0d data=0x%08h",
                   bus.wb_dst, bus.wb_data, e[RA+XLEN-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  // driver: called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [3:0] op, input int dst, input int s1, input int s2,
                       input logic hi, input int imm, input logic push,
                       input logic [XLEN-1:0] exp, output int stalls);
    bus.op = op;
    bus.dst = RA'(dst);
    bus.src1 = RA'(s1);
    bus.src2 = RA'(s2);
    bus.has_imm = hi;
    bus.imm = IMM_W'(imm);
    bus.in_valid = 1'b1;
    stalls = 0;
    while (bus.in_ready !== 1'b1 && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stayed low for %0d cycles", stalls);
    end
    @(posedge clk);
    if (push) exp_q.push_back({RA'(dst), exp});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic dbg_check(input int addr, input logic [XLEN-1:0] exp, input string name);
    dbg_addr = RA'(addr);
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int st;
    int total;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.dst = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.has_imm = 1'b0;
    bus.imm = '0;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // reset state
    check("rst_in_ready", XLEN'(bus.in_ready), 1);
    check("rst_wb_valid", XLEN'(bus.wb_valid), 0);
    check("rst_wb_dst", XLEN'(bus.wb_dst), 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_illegal", XLEN'(bus.illegal), 0);
    dbg_check(5, 0, "rst_dbg_r5");

    // back-to-back forwarding chain
    total = 0;
    issue(OP_ADD, 1, 0, 0, 1, 10, 1, 32'd10, st); total += st;
    issue(OP_ADD, 1, 1, 0, 1, 40, 1, 32'd50, st); total += st;
    issue(OP_ADD, 2, 1, 0, 1, 10, 1, 32'd60, st); total += st;
    issue(OP_ADD, 3, 2, 0, 1, 1,  1, 32'd61, st); total += st;
    issue(OP_ADD, 4, 3, 0, 1, 1,  1, 32'd62, st); total += st;
    issue(OP_SUB, 5, 4, 1, 0, 0,  1, 32'd12, st); total += st;
    issue(OP_AND, 6, 1, 2, 0, 0,  1, 32'd48, st); total += st;
    check("b2b_stalls", XLEN'(total), 0);
    idle(2);
    dbg_check(1, 50, "dbg_r1");
    dbg_check(2, 60, "dbg_r2");
    dbg_check(3, 61, "dbg_r3");
    dbg_check(4, 62, "dbg_r4");
    dbg_check(5, 12, "dbg_r5");
    dbg_check(6, 48, "dbg_r6");

    // MUL stall and forwarding from its writeback
    issue(OP_MUL, 7, 4, 5, 0, 0, 1, 32'd744, st);
    check("mul_busy_state", XLEN'(dbg_state), 1);
    issue(OP_ADD, 8, 7, 0, 1, 0, 1, 32'd744, st);
    check("mul_stall_cycles", XLEN'(st), 32);
    idle(2);
    dbg_check(7, 744, "dbg_r7");
    dbg_check(8, 744, "dbg_r8");

    // immediate sign extension, shifts, compares
    issue(OP_ADD,  1, 0, 0, 1, -1, 1, 32'hFFFF_FFFF, st);
    issue(OP_SRA,  2, 1, 0, 1, 4,  1, 32'hFFFF_FFFF, st);
    issue(OP_SRL,  3, 1, 0, 1, 4,  1, 32'h0FFF_FFFF, st);
    issue(OP_SLT,  4, 1, 0, 0, 0,  1, 32'd1, st);
    issue(OP_SLTU, 5, 1, 0, 0, 0,  1, 32'd0, st);
    issue(OP_SLL,  6, 1, 0, 1, 4,  1, 32'hFFFF_FFF0, st);
    issue(OP_XOR,  9, 1, 3, 0, 0,  1, 32'hF000_0000, st);
    issue(OP_OR,  10, 0, 0, 1, 32'h7FF, 1, 32'h0000_07FF, st);
    issue(OP_SLL, 11, 10, 0, 1, 33, 1, 32'h0000_0FFE, st);

    // wrap-around
    issue(OP_ADD,  1, 0, 0, 1, 1,  1, 32'd1, st);
    issue(OP_SLL,  1, 1, 0, 1, 31, 1, 32'h8000_0000, st);
    issue(OP_ADD,  2, 1, 1, 0, 0,  1, 32'd0, st);
    issue(OP_SLT, 12, 1, 0, 0, 0,  1, 32'd1, st);
    issue(OP_SLTU,13, 0, 1, 0, 0,  1, 32'd1, st);
    issue(OP_ADD,  3, 0, 0, 1, 1,  1, 32'd1, st);
    issue(OP_SLL,  3, 3, 0, 1, 16, 1, 32'h0001_0000, st);
    issue(OP_MUL,  4, 3, 3, 0, 0,  1, 32'd0, st);
    issue(OP_MUL,  5, 3, 0, 1, -1, 1, 32'hFFFF_0000, st);
    idle(40);
    dbg_check(2, 0, "dbg_wrap_r2");
    dbg_check(5, 32'hFFFF_0000, "dbg_mul_r5");

    // r0 sink and illegal ops
    issue(OP_ADD, 0, 0, 0, 1, 5, 1, 32'd5, st);
    issue(OP_ADD, 6, 0, 0, 1, 3, 1, 32'd3, st);
    issue(4'd12, 7, 1, 2, 0, 0, 0, 32'd0, st);
    check("illegal_pulse", XLEN'(bus.illegal), 1);
    check("illegal_no_wb", XLEN'(bus.wb_valid), 0);
    idle(1);
    check("illegal_one_cycle", XLEN'(bus.illegal), 0);
    issue(4'd15, 8, 1, 2, 0, 0, 0, 32'd0, st);
    check("illegal15_pulse", XLEN'(bus.illegal), 1);
    idle(2);
    dbg_check(0, 0, "dbg_r0");
    dbg_check(6, 3, "dbg_r6_after_r0");
    dbg_check(7, 744, "dbg_r7_unchanged");
    dbg_check(8, 744, "dbg_r8_unchanged");

    // reset in the middle of a MUL
    issue(OP_MUL, 9, 6, 6, 0, 0, 0, 32'd0, st);
    idle(9);
    reset_n = 1'b0;
    #1;
    check("midmul_in_ready", XLEN'(bus.in_ready), 1);
    check("midmul_wb_valid", XLEN'(bus.wb_valid), 0);
    for (int r = 1; r < NREGS; r++) begin
      dbg_addr = RA'(r);
      #1;
      check($sformatf("midmul_r%0d", r), dbg_data, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);
    check("post_rst_in_ready", XLEN'(bus.in_ready), 1);
    dbg_check(9, 0, "post_rst_r9");

    check("queue_drained", XLEN'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
